// File: rtl/data_mem_ctrl_pkg.sv
// data_mem_ctrl_pkg: shared access-size and controller-state encodings, latched access record
package data_mem_ctrl_pkg;
  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  typedef struct packed {
    logic        we;
    logic [1:0]  op;
    logic        ext;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;
  function automatic logic access_err(input logic [1:0] op, input logic [31:0] off, input int aw);
    return (op == 2'b11) || (op == MEM_HALF && off[0]) || (op == MEM_WORD && off[1:0] != 2'b00) ||
           ((off >> (aw + 2)) != 32'd0);
  endfunction
endpackage

// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: request/response bus between a master and the data memory controller
interface data_mem_ctrl_if;
  logic        req;
  logic        we;
  logic [1:0]  mem_op;
  logic        mem_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  modport master(output req, we, mem_op, mem_ext, addr, wdata, input ready, done, err, rdata);
  modport slave(input req, we, mem_op, mem_ext, addr, wdata, output ready, done, err, rdata);
endinterface

// File: rtl/data_mem_ctrl_ext.sv
// ext8_32 / ext16_32: zero or sign extension of a byte / halfword to 32 bits
module ext8_32 (
  input  logic [7:0]  d,
  input  logic        sx,
  output logic [31:0] q
);
  assign q = {{24{sx & d[7]}}, d};
endmodule

module ext16_32 (
  input  logic [15:0] d,
  input  logic        sx,
  output logic [31:0] q
);
  assign q = {{16{sx & d[15]}}, d};
endmodule

// File: rtl/dm_bank.sv
// dm_bank: DEPTH_WORDS x 32 storage with byte-enable synchronous write and asynchronous read
module dm_bank #(
  parameter int DEPTH_WORDS = 128,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem_q [DEPTH_WORDS];
  always_ff @(posedge clk)
    if (we)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
  assign rdata = mem_q[idx];
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-outstanding load/store controller with wait states over a byte-enabled bank
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int          DEPTH_WORDS = 128,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input logic            clk,
  input logic            rst,
  data_mem_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  acc_t        acc_q, acc_d, cur;
  logic [31:0] off, rword, wd, ext_b, ext_h, load;
  logic [3:0]  be;
  logic        bad, done;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    if (state_q == IDLE && bus.req) begin
      acc_d   = '{we: bus.we, op: bus.mem_op, ext: bus.mem_ext, addr: bus.addr, wdata: bus.wdata};
      state_d = WAIT_CYCLES > 0 ? WAIT : RESP;
      cnt_d   = WAIT_CYCLES > 0 ? 4'(WAIT_CYCLES - 1) : 4'd0;
    end else if (state_q == WAIT) begin
      state_d = cnt_q == 4'd0 ? RESP : WAIT;
      cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  // With no wait states the store commits on the accepting edge, so use the incoming access there.
  assign cur  = state_q == IDLE ? acc_d : acc_q;
  assign off  = cur.addr - BASE_ADDR;
  assign bad  = access_err(cur.op, off, AW);
  assign be   = cur.op == MEM_BYTE ? 4'b0001 << off[1:0] : cur.op == MEM_HALF ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wd   = cur.op == MEM_BYTE ? {4{cur.wdata[7:0]}} : cur.op == MEM_HALF ? {2{cur.wdata[15:0]}} : cur.wdata;
  dm_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_bank (
    .clk(clk), .we(state_d == RESP && cur.we && !bad), .be(be), .idx(off[AW+1:2]), .wdata(wd), .rdata(rword)
  );
  ext8_32  u_ext8  (.d(rword[{off[1:0], 3'b000} +: 8]), .sx(cur.ext), .q(ext_b));
  ext16_32 u_ext16 (.d(off[1] ? rword[31:16] : rword[15:0]), .sx(cur.ext), .q(ext_h));
  assign load      = cur.op == MEM_BYTE ? ext_b : cur.op == MEM_HALF ? ext_h : rword;
  assign done      = state_q == RESP;
  assign bus.ready = state_q == IDLE;
  assign bus.done  = done;
  assign bus.err   = done && bad;
  assign bus.rdata = done && !bad && !cur.we ? load : 32'd0;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed vector table plus timing/reset sequences on three wait-state configurations
module tb_data_mem_ctrl;
  import data_mem_ctrl_pkg::*;
  localparam logic [31:0] BASE = 32'h1000_0000;
  typedef struct {
    logic        we;
    logic [1:0]  op;
    logic        ext;
    logic [31:0] off;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic we = 1'b0, ext = 1'b0;
  logic [1:0] op = 2'b00;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic req [3];
  logic ready_v [3], done_v [3], err_v [3];
  logic [31:0] rdata_v [3];
  int n_pass = 0, n_total = 0;
  always #5 clk = ~clk;
  data_mem_ctrl_if b0 ();
  data_mem_ctrl_if b1 ();
  data_mem_ctrl_if b3 ();
  assign b0.req = req[0]; assign b1.req = req[1]; assign b3.req = req[2];
  assign b0.we = we; assign b1.we = we; assign b3.we = we;
  assign b0.mem_op = op; assign b1.mem_op = op; assign b3.mem_op = op;
  assign b0.mem_ext = ext; assign b1.mem_ext = ext; assign b3.mem_ext = ext;
  assign b0.addr = addr; assign b1.addr = addr; assign b3.addr = addr;
  assign b0.wdata = wdata; assign b1.wdata = wdata; assign b3.wdata = wdata;
  assign ready_v[0] = b0.ready; assign ready_v[1] = b1.ready; assign ready_v[2] = b3.ready;
  assign done_v[0] = b0.done; assign done_v[1] = b1.done; assign done_v[2] = b3.done;
  assign err_v[0] = b0.err; assign err_v[1] = b1.err; assign err_v[2] = b3.err;
  assign rdata_v[0] = b0.rdata; assign rdata_v[1] = b1.rdata; assign rdata_v[2] = b3.rdata;
  data_mem_ctrl #(.DEPTH_WORDS(128), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  data_mem_ctrl #(.DEPTH_WORDS(128), .BASE_ADDR(BASE), .WAIT_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  data_mem_ctrl #(.DEPTH_WORDS(128), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else n_pass++;
  endtask

  task automatic acc(input int k, input vec_t v, output logic seen, output logic e, output logic [31:0] rd, output int lat);
    we = v.we; op = v.op; ext = v.ext; addr = BASE + v.off; wdata = v.wdata; req[k] = 1'b1;
    seen = 1'b0; e = 1'b0; rd = 32'd0; lat = 0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(posedge clk); #1;
      req[k] = 1'b0;
      if (done_v[k]) begin seen = 1'b1; e = err_v[k]; rd = rdata_v[k]; lat = c; end
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input int k, input string tag, input vec_t v, input int exp_lat);
    logic seen, e;
    logic [31:0] rd;
    int lat;
    acc(k, v, seen, e, rd, lat);
    check({tag, " done"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " err"}, 32'(e), 32'(v.exp_err));
    check({tag, " rdata"}, rd, v.exp_rdata);
  endtask

  task automatic thr(input int k, input string tag, input int window, input int exp_cnt);
    int cnt = 0;
    we = 1'b0; op = MEM_WORD; ext = 1'b0; addr = BASE; req[k] = 1'b1;
    for (int c = 0; c < window; c++) begin
      @(posedge clk); #1;
      if (done_v[k]) cnt++;
    end
    req[k] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check({tag, " throughput"}, 32'(cnt), 32'(exp_cnt));
  endtask

  vec_t tbl [24];
  initial begin
    int dn;
    req[0] = 1'b0; req[1] = 1'b0; req[2] = 1'b0;
    tbl[0]  = '{1'b1, MEM_WORD, 1'b0, 32'd8,   32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, MEM_WORD, 1'b0, 32'd8,   32'h0,        1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, MEM_WORD, 1'b0, 32'd8,   32'h0,        1'b0, 32'h0};
    tbl[3]  = '{1'b1, MEM_BYTE, 1'b0, 32'd9,   32'h80,       1'b0, 32'h0};
    tbl[4]  = '{1'b0, MEM_BYTE, 1'b1, 32'd9,   32'h0,        1'b0, 32'hFFFFFF80};
    tbl[5]  = '{1'b0, MEM_BYTE, 1'b0, 32'd9,   32'h0,        1'b0, 32'h00000080};
    tbl[6]  = '{1'b0, MEM_WORD, 1'b0, 32'd8,   32'h0,        1'b0, 32'h00008000};
    tbl[7]  = '{1'b1, MEM_WORD, 1'b0, 32'd0,   32'h11223344, 1'b0, 32'h0};
    tbl[8]  = '{1'b1, MEM_HALF, 1'b0, 32'd3,   32'h1234,     1'b1, 32'h0};
    tbl[9]  = '{1'b0, MEM_WORD, 1'b0, 32'd0,   32'h0,        1'b0, 32'h11223344};
    tbl[10] = '{1'b0, MEM_WORD, 1'b0, 32'd2,   32'h0,        1'b1, 32'h0};
    tbl[11] = '{1'b0, MEM_WORD, 1'b0, 32'd512, 32'h0,        1'b1, 32'h0};
    tbl[12] = '{1'b0, MEM_WORD, 1'b0, 32'hFFFFFFFC, 32'h0,   1'b1, 32'h0};
    tbl[13] = '{1'b0, 2'b11,    1'b0, 32'd0,   32'h0,        1'b1, 32'h0};
    tbl[14] = '{1'b1, MEM_WORD, 1'b0, 32'd4,   32'hFFFFFFFF, 1'b0, 32'h0};
    tbl[15] = '{1'b1, MEM_HALF, 1'b0, 32'd6,   32'hA5A58001, 1'b0, 32'h0};
    tbl[16] = '{1'b0, MEM_HALF, 1'b1, 32'd6,   32'h0,        1'b0, 32'hFFFF8001};
    tbl[17] = '{1'b0, MEM_HALF, 1'b0, 32'd4,   32'h0,        1'b0, 32'h0000FFFF};
    tbl[18] = '{1'b0, MEM_WORD, 1'b0, 32'd4,   32'h0,        1'b0, 32'h8001FFFF};
    tbl[19] = '{1'b0, MEM_BYTE, 1'b0, 32'd7,   32'h0,        1'b0, 32'h00000080};
    tbl[20] = '{1'b1, MEM_WORD, 1'b0, 32'd508, 32'h55AA55AA, 1'b0, 32'h0};
    tbl[21] = '{1'b0, MEM_WORD, 1'b0, 32'd508, 32'h0,        1'b0, 32'h55AA55AA};
    tbl[22] = '{1'b1, MEM_BYTE, 1'b0, 32'd512, 32'hEE,       1'b1, 32'h0};
    tbl[23] = '{1'b0, MEM_WORD, 1'b0, 32'd0,   32'h0,        1'b0, 32'h11223344};
    #12;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset ready%0d", k), 32'(ready_v[k]), 32'd1);
      check($sformatf("reset done%0d", k), 32'(done_v[k]), 32'd0);
      check($sformatf("reset err%0d", k), 32'(err_v[k]), 32'd0);
      check($sformatf("reset rdata%0d", k), rdata_v[k], 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 24; i++) run(1, $sformatf("v%0d", i), tbl[i], 2);
    run(0, "w0 store", '{1'b1, MEM_WORD, 1'b0, 32'h20, 32'h0BADF00D, 1'b0, 32'h0}, 1);
    run(0, "w0 load", '{1'b0, MEM_WORD, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0BADF00D}, 1);
    run(0, "w0 byte", '{1'b0, MEM_BYTE, 1'b1, 32'h22, 32'h0, 1'b0, 32'hFFFFFFAD}, 1);
    run(2, "w3 store", '{1'b1, MEM_WORD, 1'b0, 32'h20, 32'h0BADF00D, 1'b0, 32'h0}, 4);
    run(2, "w3 half", '{1'b1, MEM_HALF, 1'b0, 32'h22, 32'hBEEF, 1'b0, 32'h0}, 4);
    run(2, "w3 loadh", '{1'b0, MEM_HALF, 1'b1, 32'h22, 32'h0, 1'b0, 32'hFFFFBEEF}, 4);
    run(2, "w3 loadw", '{1'b0, MEM_WORD, 1'b0, 32'h20, 32'h0, 1'b0, 32'hBEEFF00D}, 4);
    run(2, "w3 range", '{1'b0, MEM_WORD, 1'b0, 32'd512, 32'h0, 1'b1, 32'h0}, 4);
    thr(0, "w0", 12, 6);
    thr(1, "w1", 12, 4);
    thr(2, "w3", 20, 4);
    run(1, "pre-rst store", '{1'b1, MEM_WORD, 1'b0, 32'd16, 32'h12345678, 1'b0, 32'h0}, 2);
    we = 1'b1; op = MEM_WORD; ext = 1'b0; addr = BASE + 32'd16; wdata = 32'hCAFEF00D; req[1] = 1'b1;
    @(posedge clk); #1;
    req[1] = 1'b0;
    check("mid ready busy", 32'(ready_v[1]), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("mid rst ready", 32'(ready_v[1]), 32'd1);
    check("mid rst done", 32'(done_v[1]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    dn = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (done_v[1]) dn++;
    end
    check("mid rst no done", 32'(dn), 32'd0);
    run(1, "post-rst load", '{1'b0, MEM_WORD, 1'b0, 32'd16, 32'h0, 1'b0, 32'h12345678}, 2);
    run(1, "post-rst mem kept", '{1'b0, MEM_WORD, 1'b0, 32'd0, 32'h0, 1'b0, 32'h11223344}, 2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
